spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI master engine, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits between the TX FIFO and the RX FIFO. Pops one word from the TX FIFO, shifts it out on MOSI, and shifts in MISO at the same time.
- Each received word is pushed into the RX FIFO. One cs_n frame per word.

Parameters:
- DATA_WIDTH, 8, bits per SPI word and FIFO word width.
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1).
- CS_GAP, 2, minimum clk cycles cs_n stays high between frames (>=1).
- CNT_WIDTH, 8, width of the internal divider and gap counters (must hold max(CLK_DIV, CS_GAP)).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting new frames.
- tx_empty  in  1  TX FIFO empty flag.
- tx_rd_en  out  1  TX FIFO pop strobe.
- tx_rd_data  in  DATA_WIDTH  TX FIFO read data; valid only in the cycle tx_rd_en=1.
- rx_full  in  1  RX FIFO full flag.
- rx_wr_en  out  1  RX FIFO push strobe.
- rx_wr_data  out  DATA_WIDTH  received word.
- ovf_clr  in  1  clears rx_overflow.
- sclk  out  1  SPI clock.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in (pre-synchronised by the pad stage).
- cs_n  out  1  chip select, active low.
- busy  out  1  high whenever state != IDLE.
- rx_overflow  out  1  sticky: a received word was dropped.

Behaviour:
- Reset values: tx_rd_en=0, rx_wr_en=0, rx_wr_data=0, sclk=0, mosi=0, cs_n=1, busy=0, rx_overflow=0, state=IDLE, all counters 0.
- Reset mid-frame: outputs go to reset values immediately (asynchronous). The word in flight is lost; no push occurs.
- States: IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE: when enable=1 and tx_empty=0, assert tx_rd_en for exactly one cycle (cycle 0).
  - Capture tx_rd_data into the tx shift register in that same cycle; the FIFO read data is combinational and only valid during the pop.
  - Go to SETUP.
- SETUP: from cycle 1, cs_n=0, sclk=0, mosi=tx_shift[MSB]. Lasts CLK_DIV cycles, then go to SHIFT.
- SHIFT: sclk toggles every CLK_DIV cycles, first edge rising. Each half-period is exactly CLK_DIV cycles.
  - Each sclk rising edge: sample miso into rx_shift LSB, shifting left.
  - Each sclk falling edge: shift tx_shift left, so mosi shows the next bit.
  - After DATA_WIDTH rising edges and the final falling edge: sclk=0, go to DONE.
- DONE: one cycle, at cycle P = CLK_DIV*(2*DATA_WIDTH+1)+1.
  - cs_n=1, mosi=0, rx_wr_data=rx_shift.
  - If rx_full=0: rx_wr_en=1 for this cycle only.
  - If rx_full=1: no push, rx_overflow<=1.
  - Go to GAP.
- GAP: hold cs_n=1 for CS_GAP-1 further cycles, then return to IDLE. Earliest next tx_rd_en is cycle P+CS_GAP.
- cs_n is low for exactly CLK_DIV*(2*DATA_WIDTH+1) cycles per frame (cycles 1..P-1).
- enable falling mid-frame: the current frame completes normally, including the push; no new pop afterwards.
- tx_empty is only examined in IDLE. A FIFO that is empty after a pop stops the engine in IDLE with cs_n=1.
- rx_overflow:
  - Set in DONE when rx_full=1.
  - Cleared by ovf_clr=1 in a cycle with no set condition.
  - Set wins over clear in the same cycle.
- mosi never changes while sclk=1. miso is sampled only on rising-edge cycles.

Test Plan:
- Single frame (DATA_WIDTH=8, CLK_DIV=2, CS_GAP=2): TX FIFO holds 0xA5, miso driven from pattern 0x3C on sclk falling edges.
  - Required: one tx_rd_en pulse; mosi bits 1,0,1,0,0,1,0,1 at the rising edges.
  - Required: cs_n low 34 cycles; rx_wr_en one pulse with rx_wr_data=0x3C at cycle 35.
- Back-to-back: FIFO holds 0x01,0xFF with enable=1.
  - Required: second tx_rd_en exactly 2 cycles after the first rx_wr_en; cs_n high >=2 cycles between frames.
  - Required: mosi second frame all 1s.
- RX full: rx_full=1 during DONE.
  - Required: no rx_wr_en; rx_overflow=1 and stays 1 through the next frame.
  - Required: ovf_clr pulse -> rx_overflow=0 next cycle.
- Reset mid-frame: assert rst after the 3rd rising sclk edge.
  - Required: cs_n=1, sclk=0, busy=0 without waiting for a clock edge; no rx_wr_en afterwards.
  - Required: next frame after release is clean.
- Enable dropped mid-frame with FIFO non-empty.
  - Required: current frame pushes its word; no further tx_rd_en until enable=1.
- Empty FIFO with enable=1.
  - Required: tx_rd_en never asserted, cs_n=1, busy=0 for 100 cycles.

Source files
------------

// File: rtl/spi_master_ctrl_if.sv
// Bus bundle for spi_master_ctrl: FIFO handshakes, SPI pins and status.
// i_/o_ prefixes are named from the controller's side of the link.
interface spi_master_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_enable;
    logic                  i_tx_empty;
    logic                  o_tx_rd_en;
    logic [DATA_WIDTH-1:0] i_tx_rd_data;
    logic                  i_rx_full;
    logic                  o_rx_wr_en;
    logic [DATA_WIDTH-1:0] o_rx_wr_data;
    logic                  i_ovf_clr;
    logic                  o_sclk;
    logic                  o_mosi;
    logic                  i_miso;
    logic                  o_cs_n;
    logic                  o_busy;
    logic                  o_rx_overflow;

    modport master (
        input  i_enable, i_tx_empty, i_tx_rd_data, i_rx_full, i_ovf_clr, i_miso,
        output o_tx_rd_en, o_rx_wr_en, o_rx_wr_data, o_sclk, o_mosi, o_cs_n,
               o_busy, o_rx_overflow
    );

    modport slave (
        output i_enable, i_tx_empty, i_tx_rd_data, i_rx_full, i_ovf_clr, i_miso,
        input  o_tx_rd_en, o_rx_wr_en, o_rx_wr_data, o_sclk, o_mosi, o_cs_n,
               o_busy, o_rx_overflow
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, MSB first: pops a TX FIFO word, runs one cs_n frame,
// pushes the received word to the RX FIFO.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | cs_n high; pop a word when enabled and TX FIFO not empty
// S_SETUP | cs_n low, sclk low, MSB on mosi for CLK_DIV cycles
// S_SHIFT | sclk toggling, CLK_DIV cycles per half-period
// S_DONE  | one cycle: cs_n high, push word or flag overflow
// S_GAP   | cs_n held high for CS_GAP-1 more cycles
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_ctrl_if.master bus
);

    localparam int                   BIT_W   = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] HALF_LD = CNT_WIDTH'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LD  = (CS_GAP > 1) ? CNT_WIDTH'(CS_GAP - 2) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_sclk;
    logic                  r_ovf;

    logic                  w_tc;
    logic                  w_pop;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_last;
    logic                  w_cnt_ld;
    logic [CNT_WIDTH-1:0]  w_cnt_ld_val;
    logic                  w_cnt_dec;
    logic                  w_push;
    logic                  w_ovf_set;
    logic                  w_in_frame;

    assign w_tc = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_last       = 1'b0;
        w_cnt_ld     = 1'b0;
        w_cnt_ld_val = HALF_LD;
        w_cnt_dec    = 1'b0;
        w_push       = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_enable && !bus.i_tx_empty) begin
                    w_pop       = 1'b1;
                    w_cnt_ld    = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tc) begin
                    w_rise      = 1'b1;
                    w_cnt_ld    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_SHIFT: begin
                // A frame ends after the low half-period that follows the last falling edge.
                if (w_tc) begin
                    w_cnt_ld = 1'b1;
                    if (r_sclk) begin
                        w_fall = 1'b1;
                    end else if (r_bit_cnt == '0) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_rise = 1'b1;
                    end
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.i_rx_full) w_ovf_set = 1'b1;
                else               w_push    = 1'b1;
                if (CS_GAP > 1) begin
                    w_cnt_ld     = 1'b1;
                    w_cnt_ld_val = GAP_LD;
                    w_state_nxt  = S_GAP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (w_tc) w_state_nxt = S_IDLE;
                else      w_cnt_dec   = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_cnt_ld)       r_cnt <= w_cnt_ld_val;
            else if (w_cnt_dec) r_cnt <= r_cnt - CNT_WIDTH'(1);

            if (w_pop) begin
                r_tx_shift <= bus.i_tx_rd_data;
                r_bit_cnt  <= BIT_W'(DATA_WIDTH);
            end else if (w_fall) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt - BIT_W'(1);
            end

            if (w_rise) begin
                r_sclk     <= 1'b1;
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], bus.i_miso};
            end else if (w_fall) begin
                r_sclk <= 1'b0;
            end

            if (w_last) r_rx_data <= r_rx_shift;

            if (w_ovf_set)          r_ovf <= 1'b1;
            else if (bus.i_ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign w_in_frame = (r_state == S_SETUP) || (r_state == S_SHIFT);

    // The pop is decoded combinationally so capture lands in the FIFO's valid
    // cycle; masking with rst keeps the strobe low while reset is held.
    assign bus.o_tx_rd_en    = w_pop & ~rst;
    assign bus.o_rx_wr_en    = w_push;
    assign bus.o_rx_wr_data  = r_rx_data;
    assign bus.o_sclk        = r_sclk;
    assign bus.o_mosi        = w_in_frame & r_tx_shift[DATA_WIDTH-1];
    assign bus.o_cs_n        = ~w_in_frame;
    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_rx_overflow = r_ovf;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: FIFO and SPI-slave models plus a
// frame-level reference (word order, bit order, frame length, push latency).
module tb_spi_master_ctrl;

    localparam int DW = 8;
    localparam int CD = 2;
    localparam int CG = 2;
    localparam int P  = CD * (2 * DW + 1) + 1;

    typedef struct {
        logic [DW-1:0] tx;
        logic [DW-1:0] mi;
        logic          full;
        int            exp_push;
        logic          exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_master_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    spi_master_ctrl #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CD),
        .CS_GAP    (CG),
        .CNT_WIDTH (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] txq[$];
    logic [DW-1:0] misoq[$];
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] exp_rx[$];
    int            pop_log[$];
    int            push_log[$];

    logic [DW-1:0] miso_word = '0;
    int            miso_idx = 0;
    logic          slv_active = 1'b0;
    logic          slv_prev_sclk = 1'b0;

    int            pops = 0;
    int            pushes = 0;
    int            frames_done = 0;
    int            last_pop_cyc = 0;
    logic [DW-1:0] last_push_data = '0;
    logic [DW-1:0] last_frame_mosi = '0;
    logic [DW-1:0] cur_exp_rx = '0;
    logic [DW-1:0] mosi_acc = '0;
    int            rises = 0;
    int            cs_low = 0;
    int            cs_high_run = CG;
    int            mosi_bad = 0;
    int            idle_bad = 0;
    logic          prev_sclk = 1'b0;
    logic          prev_cs_n = 1'b1;
    logic          prev_mosi = 1'b0;

    vec_t          vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        bus.i_tx_empty   = (txq.size() == 0);
        bus.i_tx_rd_data = (txq.size() != 0) ? txq[0] : '0;
    endtask

    task automatic queue_word(input logic [DW-1:0] t, input logic [DW-1:0] m);
        txq.push_back(t);
        misoq.push_back(m);
        exp_tx.push_back(t);
        exp_rx.push_back(m);
        drive_fifo();
    endtask

    task automatic slave_update();
        if (bus.o_cs_n) begin
            slv_active = 1'b0;
            miso_idx   = 0;
        end else if (!slv_active) begin
            slv_active = 1'b1;
            miso_idx   = 0;
            miso_word  = (misoq.size() != 0) ? misoq.pop_front() : '0;
        end else if (slv_prev_sclk && !bus.o_sclk) begin
            miso_idx++;
        end
        slv_prev_sclk = bus.o_sclk;
        bus.i_miso = (miso_idx < DW) ? miso_word[DW-1-miso_idx] : 1'b0;
    endtask

    task automatic sample();
        logic frame_end;
        frame_end = 1'b0;
        if (bus.o_tx_rd_en) begin
            pops++;
            pop_log.push_back(cyc);
            last_pop_cyc = cyc;
        end
        if (!bus.o_cs_n) begin
            if (prev_cs_n && frames_done > 0) check("cs_gap_min", cs_high_run >= CG, 1);
            cs_low++;
            cs_high_run = 0;
            if (bus.o_sclk && !prev_sclk) begin
                mosi_acc = {mosi_acc[DW-2:0], bus.o_mosi};
                rises++;
            end
            if (bus.o_sclk && prev_sclk && (bus.o_mosi != prev_mosi)) mosi_bad++;
        end else begin
            cs_high_run++;
            if (bus.o_mosi !== 1'b0 || bus.o_sclk !== 1'b0) idle_bad++;
            if (!prev_cs_n) begin
                frame_end = 1'b1;
                frames_done++;
                check("frame_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) begin
                    check("frame_mosi", mosi_acc, exp_tx.pop_front());
                    cur_exp_rx = exp_rx.pop_front();
                end
                check("frame_rises", rises, DW);
                check("frame_cs_low", cs_low, CD * (2 * DW + 1));
                last_frame_mosi = mosi_acc;
                mosi_acc = '0;
                rises    = 0;
                cs_low   = 0;
            end
        end
        if (bus.o_rx_wr_en) begin
            pushes++;
            push_log.push_back(cyc);
            last_push_data = bus.o_rx_wr_data;
            check("push_at_frame_end", frame_end, 1);
            check("push_data", bus.o_rx_wr_data, cur_exp_rx);
            check("push_latency", cyc - last_pop_cyc, P);
        end
        prev_sclk = bus.o_sclk;
        prev_cs_n = bus.o_cs_n;
        prev_mosi = bus.o_mosi;
    endtask

    task automatic tick();
        logic popped;
        @(negedge clk);
        popped = bus.o_tx_rd_en;
        sample();
        @(posedge clk);
        #1;
        cyc++;
        if (popped && txq.size() != 0) void'(txq.pop_front());
        drive_fifo();
        slave_update();
    endtask

    task automatic wait_pushes(input int n, input int budget);
        int k;
        k = 0;
        while (pushes < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_push_in_budget", pushes >= n, 1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_frame_in_budget", frames_done >= n, 1);
    endtask

    initial begin
        int            p0, q0, f0, pl, ul, k, bad;
        logic          saw_low;
        logic [DW-1:0] rt, rm;

        vecs[0] = '{8'h00, 8'hFF, 1'b0, 1, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b0, 1, 1'b0};
        vecs[2] = '{8'h5A, 8'hC3, 1'b0, 1, 1'b0};
        vecs[3] = '{8'h81, 8'h7E, 1'b1, 0, 1'b1};
        vecs[4] = '{8'h0F, 8'hF0, 1'b0, 1, 1'b1};

        rst           = 1'b1;
        bus.i_enable  = 1'b1;
        bus.i_rx_full = 1'b0;
        bus.i_ovf_clr = 1'b0;
        bus.i_miso    = 1'b0;
        queue_word(8'hA5, 8'h3C);
        repeat (3) tick();

        // reset values, with enable=1 and a word waiting
        check("rst_tx_rd_en", bus.o_tx_rd_en, 0);
        check("rst_rx_wr_en", bus.o_rx_wr_en, 0);
        check("rst_rx_wr_data", bus.o_rx_wr_data, 0);
        check("rst_sclk", bus.o_sclk, 0);
        check("rst_mosi", bus.o_mosi, 0);
        check("rst_cs_n", bus.o_cs_n, 1);
        check("rst_busy", bus.o_busy, 0);
        check("rst_ovf", bus.o_rx_overflow, 0);

        // single frame A5 / 3C
        rst = 1'b0;
        wait_pushes(1, 100);
        check("single_pops", pops, 1);
        check("single_rx_data", last_push_data, 8'h3C);
        check("single_mosi_bits", last_frame_mosi, 8'hA5);
        if (push_log.size() > 0 && pop_log.size() > 0)
            check("single_push_cycle", push_log[0] - pop_log[0], 35);
        repeat (CG + 1) tick();

        // back-to-back
        bus.i_enable = 1'b0;
        pl = pop_log.size();
        ul = push_log.size();
        p0 = pushes;
        queue_word(8'h01, 8'h96);
        queue_word(8'hFF, 8'h69);
        bus.i_enable = 1'b1;
        wait_pushes(p0 + 2, 200);
        if (pop_log.size() >= pl + 2 && push_log.size() >= ul + 1)
            check("b2b_pop_after_push", pop_log[pl+1] - push_log[ul], CG);
        check("b2b_second_mosi", last_frame_mosi, 8'hFF);
        check("b2b_second_rx", last_push_data, 8'h69);
        repeat (CG + 1) tick();

        // table-driven frames
        for (int i = 0; i < 5; i++) begin
            bus.i_rx_full = vecs[i].full;
            p0 = pushes;
            f0 = frames_done;
            queue_word(vecs[i].tx, vecs[i].mi);
            wait_frames(f0 + 1, 200);
            repeat (CG + 1) tick();
            check($sformatf("vec%0d_pushes", i), pushes - p0, vecs[i].exp_push);
            check($sformatf("vec%0d_ovf", i), bus.o_rx_overflow, vecs[i].exp_ovf);
            if (vecs[i].exp_push != 0) check($sformatf("vec%0d_data", i), last_push_data, vecs[i].mi);
        end
        bus.i_rx_full = 1'b0;

        // overflow clear, then set-wins-over-clear in DONE
        bus.i_ovf_clr = 1'b1;
        tick();
        bus.i_ovf_clr = 1'b0;
        check("ovf_cleared", bus.o_rx_overflow, 0);
        bus.i_rx_full = 1'b1;
        p0 = pushes;
        queue_word(8'hE7, 8'h18);
        saw_low = 1'b0;
        k = 0;
        while (k < 200) begin
            tick();
            k++;
            if (!bus.o_cs_n) saw_low = 1'b1;
            if (saw_low && bus.o_cs_n) break;
        end
        check("ovf_reached_done", saw_low && bus.o_cs_n && bus.o_busy, 1);
        bus.i_ovf_clr = 1'b1;
        tick();
        bus.i_ovf_clr = 1'b0;
        check("ovf_set_wins", bus.o_rx_overflow, 1);
        check("ovf_full_no_push", pushes - p0, 0);
        bus.i_rx_full = 1'b0;
        repeat (CG + 1) tick();
        bus.i_ovf_clr = 1'b1;
        tick();
        bus.i_ovf_clr = 1'b0;
        check("ovf_cleared_again", bus.o_rx_overflow, 0);

        // enable dropped mid-frame with a second word waiting
        bus.i_enable = 1'b0;
        p0 = pushes;
        q0 = pops;
        queue_word(8'h3C, 8'hA7);
        queue_word(8'hC3, 8'h5B);
        bus.i_enable = 1'b1;
        k = 0;
        while (rises < 2 && k < 100) begin
            tick();
            k++;
        end
        bus.i_enable = 1'b0;
        wait_pushes(p0 + 1, 100);
        repeat (60) tick();
        check("en_drop_pops", pops - q0, 1);
        check("en_drop_pushes", pushes - p0, 1);
        check("en_drop_data", last_push_data, 8'hA7);
        check("en_drop_idle_busy", bus.o_busy, 0);
        check("en_drop_idle_cs_n", bus.o_cs_n, 1);
        bus.i_enable = 1'b1;
        wait_pushes(p0 + 2, 100);
        check("en_resume_pops", pops - q0, 2);
        check("en_resume_data", last_push_data, 8'h5B);
        repeat (CG + 1) tick();

        // reset after the 3rd rising sclk edge
        p0 = pushes;
        q0 = pops;
        queue_word(8'h96, 8'hD2);
        k = 0;
        while (rises < 3 && k < 100) begin
            tick();
            k++;
        end
        check("rst_mid_reached", rises, 3);
        rst = 1'b1;
        #1;
        check("rst_mid_cs_n", bus.o_cs_n, 1);
        check("rst_mid_sclk", bus.o_sclk, 0);
        check("rst_mid_busy", bus.o_busy, 0);
        check("rst_mid_mosi", bus.o_mosi, 0);
        prev_cs_n   = 1'b1;
        prev_sclk   = 1'b0;
        prev_mosi   = 1'b0;
        mosi_acc    = '0;
        rises       = 0;
        cs_low      = 0;
        cs_high_run = CG;
        if (exp_tx.size() != 0) void'(exp_tx.pop_front());
        if (exp_rx.size() != 0) void'(exp_rx.pop_front());
        repeat (3) tick();
        rst = 1'b0;
        repeat (60) tick();
        check("rst_mid_no_push", pushes - p0, 0);
        check("rst_mid_pops", pops - q0, 1);
        queue_word(8'h4B, 8'hB4);
        wait_pushes(p0 + 1, 100);
        check("rst_next_data", last_push_data, 8'hB4);
        check("rst_next_mosi", last_frame_mosi, 8'h4B);
        repeat (CG + 1) tick();

        // empty FIFO with enable held high
        q0 = pops;
        bad = 0;
        repeat (100) begin
            tick();
            if (bus.o_cs_n !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_tx_rd_en !== 1'b0) bad++;
        end
        check("empty_idle_cycles_bad", bad, 0);
        check("empty_no_pop", pops - q0, 0);

        // randomized words, random spacing
        f0 = frames_done;
        for (int r = 0; r < 24; r++) begin
            rt = DW'($urandom);
            rm = DW'($urandom);
            queue_word(rt, rm);
            repeat ($urandom_range(0, 50)) tick();
        end
        wait_frames(f0 + 24, 24 * (P + CG + 4));
        repeat (CG + 2) tick();
        check("rand_all_consumed", exp_tx.size(), 0);
        check("rand_fifo_drained", txq.size(), 0);

        check("mosi_stable_while_sclk_high", mosi_bad, 0);
        check("idle_pins_low", idle_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
